uart_tx_buffered: RTL

// - Buffered UART transmitter: takes bytes over a valid/ready handshake into a small FIFO.
// - Serialises each byte as start(0), data LSB-first, optional even parity, stop(1).
// - Same frame format the receive path expects; sits between the register/host side and the tx pin.
// - Back-to-back frames with no idle gap when the FIFO holds data.

---
 rtl/uart_tx_buffered.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO in front of a start/data/parity/stop serialiser.
// Frames run back to back while the FIFO holds data.
module uart_tx_buffered #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          ovf_err,
  input  logic                          err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;

  state_t                state, state_n;
  logic [TW-1:0]         tmr, tmr_n;
  logic [BW-1:0]         idx, idx_n;
  logic [DATA_WIDTH-1:0] sh, sh_n;
  logic                  par, par_n;
  logic                  tx_d;
  logic                  last;

  assign full       = (count == CW'(FIFO_DEPTH));
  assign push       = tx_valid & ~full;
  assign head       = mem[rd_ptr];
  assign tx_ready   = ~full;
  assign fifo_count = count;
  assign tx_busy    = (state != IDLE);
  assign last       = (tmr == TW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      // a fresh overflow outranks a clear in the same cycle
      if (tx_valid && full) ovf_err <= 1'b1;
      else if (err_clr)     ovf_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      tmr   <= '0;
      idx   <= '0;
      sh    <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      tmr   <= tmr_n;
      idx   <= idx_n;
      sh    <= sh_n;
      par   <= par_n;
      tx    <= tx_d;
    end
  end

  always_comb begin
    state_n = state;
    tmr_n   = tmr + 1'b1;
    idx_n   = idx;
    sh_n    = sh;
    par_n   = par;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        tmr_n = '0;
        if (count != '0) begin
          pop     = 1'b1;
          state_n = START;
          sh_n    = head;
          par_n   = ^head;
        end
      end
      START: begin
        if (last) begin
          state_n = DATA;
          tmr_n   = '0;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (last) begin
          tmr_n = '0;
          sh_n  = sh >> 1;
          idx_n = idx + 1'b1;
          if (idx == BW'(DATA_WIDTH - 1))
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (last) begin
          state_n = STOP;
          tmr_n   = '0;
        end
      end
      STOP: begin
        if (last) begin
          tmr_n = '0;
          if (count != '0) begin
            pop     = 1'b1;
            state_n = START;
            sh_n    = head;
            par_n   = ^head;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // line level follows the next state so tx changes with the state itself
  always_comb begin
    tx_d = 1'b1;
    unique case (state_n)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_n[0];
      PARITY:  tx_d = par_n;
      default: tx_d = 1'b1;
    endcase
  end

endmodule
